// File: rtl/edge_delay_gen_pkg.sv
// edge_delay_gen shared types, defaults and helpers.
// Optional pulse mode: EDGE_DELAY_GEN_PULSE_EN.
package edge_delay_gen_pkg;

  localparam int NCH_DEF = 2;
  localparam int DW_DEF  = 16;
  localparam int PW_DEF  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    HIGH  = 2'd2
  } state_e;

  // Zero is treated as one so a kick always yields an edge.
  function automatic logic [31:0] sat1(
    input logic [31:0] x
  );
    return (x == 32'd0) ? 32'd1 : x;
  endfunction

endpackage

// File: rtl/edge_delay_gen_if.sv
// Controller-to-generator bundle for edge_delay_gen.
// pwidth exists only with EDGE_DELAY_GEN_PULSE_EN.
interface edge_delay_gen_if
  import edge_delay_gen_pkg::*;
#(
  parameter int NCH = NCH_DEF,
  parameter int DW  = DW_DEF,
  parameter int PW  = PW_DEF
) ();

  logic [NCH-1:0]    start;
  logic [NCH-1:0]    clear;
  logic [NCH*DW-1:0] delay;
`ifdef EDGE_DELAY_GEN_PULSE_EN
  logic [NCH*PW-1:0] pwidth;
`endif
  logic [NCH-1:0]    sig_o;
  logic [NCH-1:0]    busy;
  logic [NCH-1:0]    done;
  logic [NCH-1:0]    err_retrig;

  modport master (
    output start,
    output clear,
    output delay,
`ifdef EDGE_DELAY_GEN_PULSE_EN
    output pwidth,
`endif
    input  sig_o,
    input  busy,
    input  done,
    input  err_retrig
  );

  modport slave (
    input  start,
    input  clear,
    input  delay,
`ifdef EDGE_DELAY_GEN_PULSE_EN
    input  pwidth,
`endif
    output sig_o,
    output busy,
    output done,
    output err_retrig
  );

endinterface

// File: rtl/edge_delay_ch.sv
// One delay channel: FSM, down-counter, output regs.
// Pulse mode (EDGE_DELAY_GEN_PULSE_EN) self-drops HIGH.
module edge_delay_ch
  import edge_delay_gen_pkg::*;
#(
  parameter int DW = DW_DEF
`ifdef EDGE_DELAY_GEN_PULSE_EN
  ,
  parameter int PW = PW_DEF
`endif
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start_i,
  input  logic          clear_i,
  input  logic [DW-1:0] delay_i,
`ifdef EDGE_DELAY_GEN_PULSE_EN
  input  logic [PW-1:0] pwidth_i,
`endif
  output logic          sig_o,
  output logic          busy_o,
  output logic          done_o,
  output logic          err_o
);

  state_e        state_q, state_d;
  logic [DW-1:0] cnt_q, cnt_d;
  logic          sig_q, sig_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
`ifdef EDGE_DELAY_GEN_PULSE_EN
  logic [PW-1:0] pcnt_q, pcnt_d;
`endif

  logic kick;
  assign kick = start_i & ~clear_i;

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sig_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef EDGE_DELAY_GEN_PULSE_EN
      pcnt_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sig_q   <= sig_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
`ifdef EDGE_DELAY_GEN_PULSE_EN
      pcnt_q  <= pcnt_d;
`endif
    end
  end

  // Next-state: clear beats start everywhere.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sig_d   = sig_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
`ifdef EDGE_DELAY_GEN_PULSE_EN
    pcnt_d  = pcnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (kick) begin
          state_d = COUNT;
          cnt_d   = DW'(sat1(32'(delay_i)));
          busy_d  = 1'b1;
        end
      end
      COUNT: begin
        err_d = kick;
        if (clear_i) begin
          state_d = IDLE;
          cnt_d   = '0;
          busy_d  = 1'b0;
        end else if (cnt_q == DW'(1)) begin
          state_d = HIGH;
          cnt_d   = '0;
          sig_d   = 1'b1;
          done_d  = 1'b1;
          busy_d  = 1'b0;
`ifdef EDGE_DELAY_GEN_PULSE_EN
          pcnt_d  = PW'(sat1(32'(pwidth_i)));
`endif
        end else begin
          cnt_d = cnt_q - DW'(1);
        end
      end
      HIGH: begin
        err_d = kick;
        if (clear_i) begin
          state_d = IDLE;
          sig_d   = 1'b0;
`ifdef EDGE_DELAY_GEN_PULSE_EN
          pcnt_d  = '0;
        end else if (pcnt_q == PW'(1)) begin
          state_d = IDLE;
          sig_d   = 1'b0;
          pcnt_d  = '0;
        end else begin
          pcnt_d  = pcnt_q - PW'(1);
`endif
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        sig_d   = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign sig_o  = sig_q;
  assign busy_o = busy_q;
  assign done_o = done_q;
  assign err_o  = err_q;

endmodule

// File: rtl/edge_delay_gen.sv
// Multi-channel kick-to-edge delay generator top.
// Optional pulse mode: EDGE_DELAY_GEN_PULSE_EN.
module edge_delay_gen
  import edge_delay_gen_pkg::*;
#(
  parameter int NCH = NCH_DEF,
  parameter int DW  = DW_DEF,
  parameter int PW  = PW_DEF
) (
  input logic             clk,
  input logic             rst_n,
  edge_delay_gen_if.slave bus
);

  // sat1 works on 32 bits, which bounds both widths.
  if (NCH < 1 || DW < 1 || DW > 32 ||
      PW < 1 || PW > 32) begin : g_bad_cfg
    $error("edge_delay_gen: bad NCH/DW/PW");
  end

  logic [NCH-1:0] sig_w;
  logic [NCH-1:0] busy_w;
  logic [NCH-1:0] done_w;
  logic [NCH-1:0] err_w;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    edge_delay_ch #(
      .DW(DW)
`ifdef EDGE_DELAY_GEN_PULSE_EN
      ,
      .PW(PW)
`endif
    ) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .start_i  (bus.start[i]),
      .clear_i  (bus.clear[i]),
      .delay_i  (bus.delay[i*DW +: DW]),
`ifdef EDGE_DELAY_GEN_PULSE_EN
      .pwidth_i (bus.pwidth[i*PW +: PW]),
`endif
      .sig_o    (sig_w[i]),
      .busy_o   (busy_w[i]),
      .done_o   (done_w[i]),
      .err_o    (err_w[i])
    );
  end

  assign bus.sig_o      = sig_w;
  assign bus.busy       = busy_w;
  assign bus.done       = done_w;
  assign bus.err_retrig = err_w;

endmodule

// File: tb/tb_edge_delay_gen.sv
// Bench for edge_delay_gen: directed steps + random.
// Reference is an event-time model of kick/edge times.
module tb_edge_delay_gen;
  import edge_delay_gen_pkg::*;

  localparam int NCH = 2;
  localparam int DW  = 16;
  localparam int PW  = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  edge_delay_gen_if #(
    .NCH(NCH), .DW(DW), .PW(PW)
  ) bif ();

  edge_delay_gen #(
    .NCH(NCH), .DW(DW), .PW(PW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  bit m_arm  [NCH];
  bit m_high [NCH];
  int m_rise [NCH];
  int m_fall [NCH];
  logic [NCH-1:0] e_sig, e_busy;
  logic [NCH-1:0] e_done, e_err;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s cyc=%0d got=%0h exp=%0h",
             tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_arm[i]  = 1'b0;
      m_high[i] = 1'b0;
      m_rise[i] = 0;
      m_fall[i] = 0;
    end
    e_sig  = '0;
    e_busy = '0;
    e_done = '0;
    e_err  = '0;
  endtask

  // One rising edge of the reference.
  task automatic model_edge();
    cyc++;
    for (int i = 0; i < NCH; i++) begin
      logic st, cl;
      int   d;
      int   pw;
      st = bif.start[i];
      cl = bif.clear[i];
      d  = int'(bif.delay[i*DW +: DW]);
      pw = 1;
`ifdef EDGE_DELAY_GEN_PULSE_EN
      pw = int'(bif.pwidth[i*PW +: PW]);
      if (pw == 0) pw = 1;
`endif
      e_done[i] = 1'b0;
      e_err[i]  = st && !cl &&
                  (m_arm[i] || m_high[i]);
      if (cl) begin
        m_arm[i]  = 1'b0;
        m_high[i] = 1'b0;
      end else if (m_arm[i] &&
                   cyc == m_rise[i]) begin
        m_arm[i]  = 1'b0;
        m_high[i] = 1'b1;
        e_done[i] = 1'b1;
        m_fall[i] = cyc + pw;
      end
`ifdef EDGE_DELAY_GEN_PULSE_EN
      else if (m_high[i] &&
               cyc == m_fall[i]) begin
        m_high[i] = 1'b0;
      end
`endif
      else if (!m_arm[i] && !m_high[i] &&
               st) begin
        m_arm[i]  = 1'b1;
        m_rise[i] = cyc + ((d == 0) ? 1 : d);
      end
      e_sig[i]  = m_high[i];
      e_busy[i] = m_arm[i];
    end
  endtask

  task automatic check_out();
    chk("sig_o", 32'(bif.sig_o), 32'(e_sig));
    chk("busy", 32'(bif.busy), 32'(e_busy));
    chk("done", 32'(bif.done), 32'(e_done));
    chk("err_retrig", 32'(bif.err_retrig),
        32'(e_err));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_out();
  endtask

  task automatic set_dly(
    input int ch, input int d
  );
    bif.delay[ch*DW +: DW] = DW'(d);
  endtask

  task automatic idle_in();
    bif.start = '0;
    bif.clear = '0;
  endtask

  int k, r0, r1, b0, b1;

  initial begin
    rst_n     = 1'b1;
    bif.start = '0;
    bif.clear = '0;
    bif.delay = '0;
`ifdef EDGE_DELAY_GEN_PULSE_EN
    bif.pwidth = '0;
`endif
    model_reset();

    // reset, then quiet idle
    #2 rst_n = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      check_out();
    end
    rst_n = 1'b1;
    repeat (10) step();

`ifdef EDGE_DELAY_GEN_PULSE_EN
    bif.pwidth = {NCH{PW'(200)}};
`endif

    // basic delays 5 and 12
    set_dly(0, 5);
    set_dly(1, 12);
    bif.start = 2'b11;
    step();
    k = cyc;
    idle_in();
    r0 = -1; r1 = -1; b0 = 1; b1 = 1;
    for (int s = 0; s < 16; s++) begin
      step();
      if (bif.sig_o[0] && r0 < 0) r0 = cyc;
      if (bif.sig_o[1] && r1 < 0) r1 = cyc;
      if (bif.busy[0]) b0++;
      if (bif.busy[1]) b1++;
    end
    chk("lat_ch0", 32'(r0 - k), 32'd5);
    chk("lat_ch1", 32'(r1 - k), 32'd12);
    chk("busy_len0", 32'(b0), 32'd5);
    chk("busy_len1", 32'(b1), 32'd12);
    bif.clear = 2'b11;
    step();
    idle_in();
    step();

    // delay 0 and 1 both give one cycle
    set_dly(0, 0);
    set_dly(1, 1);
    bif.start = 2'b11;
    step();
    idle_in();
    step();
    chk("d0_d1_rise", 32'(bif.sig_o), 32'd3);
    bif.clear = 2'b11;
    step();
    idle_in();
    step();

    // abort mid-count
    set_dly(0, 10);
    bif.start = 2'b01;
    step();
    idle_in();
    repeat (3) step();
    bif.clear = 2'b01;
    step();
    idle_in();
    chk("abort_busy", 32'(bif.busy[0]), 32'd0);
    repeat (10) step();

    // start+clear together in idle
    bif.start = 2'b01;
    bif.clear = 2'b01;
    step();
    idle_in();
    chk("sc_err", 32'(bif.err_retrig[0]), 32'd0);
    chk("sc_busy", 32'(bif.busy[0]), 32'd0);
    step();

    // retrigger while counting and high
    set_dly(0, 8);
    bif.start = 2'b01;
    step();
    idle_in();
    repeat (2) step();
    bif.start = 2'b01;
    set_dly(0, 2);
    step();
    idle_in();
    chk("retrig_cnt", 32'(bif.err_retrig[0]), 32'd1);
    repeat (4) step();
    chk("pre_edge", 32'(bif.sig_o[0]), 32'd0);
    step();
    chk("retrig_edge", 32'(bif.sig_o[0]), 32'd1);
    bif.start = 2'b01;
    step();
    idle_in();
    chk("retrig_high", 32'(bif.err_retrig[0]), 32'd1);
    chk("high_hold", 32'(bif.sig_o[0]), 32'd1);
    bif.clear = 2'b01;
    step();
    idle_in();
    step();

    // async reset mid-count
    set_dly(0, 20);
    bif.start = 2'b01;
    step();
    idle_in();
    repeat (7) step();
    chk("pre_rst_busy", 32'(bif.busy[0]), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst_busy", 32'(bif.busy), 32'd0);
    check_out();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (25) step();

`ifdef EDGE_DELAY_GEN_PULSE_EN
    // self-timed pulse: delay 3, width 4
    set_dly(0, 3);
    bif.pwidth[0 +: PW] = PW'(4);
    bif.start = 2'b01;
    step();
    idle_in();
    repeat (3) step();
    chk("pulse_rise", 32'(bif.sig_o[0]), 32'd1);
    repeat (3) step();
    chk("pulse_hold", 32'(bif.sig_o[0]), 32'd1);
    step();
    chk("pulse_fall", 32'(bif.sig_o[0]), 32'd0);
    repeat (3) step();
`endif

    // random traffic
    for (int s = 0; s < 600; s++) begin
      for (int i = 0; i < NCH; i++) begin
        bif.start[i] = ($urandom_range(0, 5) == 0);
        bif.clear[i] = ($urandom_range(0, 11) == 0);
        set_dly(i, $urandom_range(0, 14));
`ifdef EDGE_DELAY_GEN_PULSE_EN
        bif.pwidth[i*PW +: PW] =
          PW'($urandom_range(0, 6));
`endif
      end
      step();
      if (s % 150 == 75) begin
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_out();
        @(negedge clk);
        rst_n = 1'b1;
      end
    end
    idle_in();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
